// File: rtl/mem_burst_ctrl.sv
// Line-transfer controller between the cache and a single-port delayed main
// memory. Accepts one line fill or writeback of BURST_LEN words, drives the
// memory for the whole burst and answers with a one-cycle response pulse.
module mem_burst_ctrl #(
    parameter int BURST_LEN    = 4,
    parameter int DELAY_CYCLES = 10
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic                   REQ_WRITE,
    input  logic [31:0]            REQ_ADDR,
    input  logic [32*BURST_LEN-1:0] REQ_WDATA,
    output logic                   RSP_VALID,
    output logic [32*BURST_LEN-1:0] RSP_RDATA,
    output logic                   MEM_RE,
    output logic                   MEM_WE,
    output logic [31:0]            MEM_ADDR,
    output logic [31:0]            MEM_DIN,
    input  logic                   MEM_VALID,
    input  logic [31:0]            MEM_DOUT
);

    localparam int BEAT_W    = $clog2(BURST_LEN);
    // Long enough for a burst aborted by reset to run out in the memory.
    localparam int DRAIN_LEN = DELAY_CYCLES + BURST_LEN + 2;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN);
    localparam logic [31:0] ALIGN_MASK = ~(32'(BURST_LEN) - 32'd1);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   next_beat;
    logic                last_beat;
    logic [31:0]         base;
    // Holds the write line during a writeback and collects beats during a fill.
    logic [31:0]         line_buf [BURST_LEN];

    assign REQ_READY = (state == S_IDLE);
    assign next_beat = beat + BEAT_W'(1);
    assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));

    // Line buffer: load the write line on accept, capture read beats in a fill.
    // NOTE: pure datapath storage has no reset; every word is rewritten before
    // it is used, and keeping it out of the reset tree lets it map to plain flops/RAM.
    always_ff @(posedge CLK) begin
        if (state == S_IDLE && REQ_VALID) begin
            for (int i = 0; i < BURST_LEN; i++) begin
                line_buf[i] <= REQ_WDATA[32*i +: 32];
            end
        end else if (state == S_READ && MEM_VALID) begin
            line_buf[beat] <= MEM_DOUT;
        end
    end

    // Control FSM with registered memory and response outputs.
    // NOTE: every register here is assigned with <= so all of them see the
    // values from before the edge, exactly as the flops will in hardware.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
            beat      <= '0;
            base      <= '0;
            MEM_RE    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_DIN   <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
        end else begin
            case (state)
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(DRAIN_LEN - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end

                S_IDLE: begin
                    if (REQ_VALID) begin
                        base     <= REQ_ADDR & ALIGN_MASK;
                        MEM_ADDR <= REQ_ADDR & ALIGN_MASK;
                        beat     <= '0;
                        if (REQ_WRITE) begin
                            MEM_WE  <= 1'b1;
                            MEM_DIN <= REQ_WDATA[31:0];
                            state   <= S_WRITE;
                        end else begin
                            MEM_RE  <= 1'b1;
                            state   <= S_READ;
                        end
                    end
                end

                S_READ, S_WRITE: begin
                    if (MEM_VALID) begin
                        if (last_beat) begin
                            // Drop the enables on the final beat so the memory
                            // never sees a request once its burst ends.
                            MEM_RE    <= 1'b0;
                            MEM_WE    <= 1'b0;
                            RSP_VALID <= 1'b1;
                            state     <= S_DONE;
                            if (state == S_READ) begin
                                for (int i = 0; i < BURST_LEN; i++) begin
                                    RSP_RDATA[32*i +: 32] <= (BEAT_W'(i) == beat) ? MEM_DOUT
                                                                                  : line_buf[i];
                                end
                            end
                        end else begin
                            beat     <= next_beat;
                            MEM_ADDR <= base + 32'(next_beat);
                            if (state == S_WRITE) begin
                                MEM_DIN <= line_buf[next_beat];
                            end
                        end
                    end
                end

                S_DONE: begin
                    RSP_VALID <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_DRAIN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: a delayed single-port memory model
// plus a line-level reference memory that predicts fills, writebacks and the
// edge-by-edge timing of every burst.
module tb_mem_burst_ctrl;

    localparam int B       = 4;
    localparam int D       = 10;
    localparam int LW      = 32 * B;
    localparam int EXP_EN  = D + B + 1;   // enable high after E0..E(D+B)
    localparam int EXP_RSP = D + B + 1;   // response seen after E(D+B+1)
    localparam int EXP_RDY = D + B + 2;   // ready again after E(D+B+2)
    localparam int DRAIN   = D + B + 2;
    localparam int WIN     = D + B + 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WRITE;
    logic [31:0]   REQ_ADDR;
    logic [LW-1:0] REQ_WDATA;
    logic          RSP_VALID;
    logic [LW-1:0] RSP_RDATA;
    logic          MEM_RE;
    logic          MEM_WE;
    logic [31:0]   MEM_ADDR;
    logic [31:0]   MEM_DIN;
    logic          MEM_VALID;
    logic [31:0]   MEM_DOUT;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    mem_burst_ctrl #(.BURST_LEN(B), .DELAY_CYCLES(D)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
        .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_VALID(MEM_VALID), .MEM_DOUT(MEM_DOUT)
    );

    // ---------------- delayed memory model (environment) ----------------
    logic [31:0] mem [256];
    logic        mem_valid = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_wr = 1'b0;
    int          m_cnt = 0;
    int          m_bursts = 0;
    int          m_beats = 0;

    assign MEM_VALID = mem_valid;
    assign MEM_DOUT  = mem_valid ? mem[MEM_ADDR[7:0]] : 32'hDEAD_BEEF;

    // Memory samples RE/WE when idle, waits D cycles, then gives B beats.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < B; i++) mem[32'h40 + i] = 32'hA0 + i;
        forever begin
            @(posedge CLK);
            if (!m_busy) begin
                if (MEM_RE || MEM_WE) begin
                    m_busy = 1'b1;
                    m_wr   = MEM_WE;
                    m_cnt  = 0;
                    m_bursts++;
                end
            end else begin
                if (mem_valid) begin
                    m_beats++;
                    if (m_wr) mem[MEM_ADDR[7:0]] <= MEM_DIN;
                end
                if (m_cnt == D - 1) mem_valid <= 1'b1;
                if (m_cnt == D + B - 1) begin
                    mem_valid <= 1'b0;
                    m_busy = 1'b0;
                end
                m_cnt++;
            end
        end
    end

    // Protocol monitor: read and write enables must never overlap.
    int both_viol = 0;
    always @(negedge CLK) begin
        if (MEM_RE === 1'b1 && MEM_WE === 1'b1) both_viol++;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0]   ref_mem [256];
    logic [LW-1:0] last_line;

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~(32'(B) - 32'd1);
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [31:0] base);
        logic [LW-1:0] r;
        logic [31:0]   a;
        for (int i = 0; i < B; i++) begin
            a = base + 32'(i);
            r[32*i +: 32] = ref_mem[a[7:0]];
        end
        return r;
    endfunction

    task automatic ref_write(input logic [31:0] base, input logic [LW-1:0] line);
        logic [31:0] a;
        for (int i = 0; i < B; i++) begin
            a = base + 32'(i);
            ref_mem[a[7:0]] = line[32*i +: 32];
        end
    endtask

    // Word index the memory bus should show after edge E_k of a burst.
    function automatic int beat_at(input int k);
        int c;
        c = k - (D + 1);
        if (c < 0) c = 0;
        if (c > B - 1) c = B - 1;
        return c;
    endfunction

    // ---------------- transaction driver / observer ----------------
    int            obs_wait, obs_rsp_k, obs_rsp_cnt, obs_en_cnt, obs_other_cnt, obs_ready_k;
    logic [LW-1:0] obs_line, obs_rdata_end;
    logic [31:0]   addr_tr [WIN+1];
    logic [31:0]   din_tr  [WIN+1];

    // Issues one request and records what the DUT shows after E0..E(WIN).
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [LW-1:0] wdata,
                          input bit hold, input int pulse_k);
        logic act, other;
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        obs_wait  = 0;
        while (REQ_READY !== 1'b1 && obs_wait < 100) begin
            @(negedge CLK);
            obs_wait++;
        end
        @(posedge CLK);
        obs_rsp_k = -1; obs_rsp_cnt = 0; obs_en_cnt = 0; obs_other_cnt = 0; obs_ready_k = -1;
        obs_line = '0;
        for (int k = 0; k <= WIN; k++) begin
            @(negedge CLK);
            act   = wr ? MEM_WE : MEM_RE;
            other = wr ? MEM_RE : MEM_WE;
            if (act === 1'b1) obs_en_cnt++;
            if (other !== 1'b0) obs_other_cnt++;
            addr_tr[k] = MEM_ADDR;
            din_tr[k]  = MEM_DIN;
            if (RSP_VALID === 1'b1) begin
                obs_rsp_cnt++;
                if (obs_rsp_k < 0) begin
                    obs_rsp_k = k;
                    obs_line  = RSP_RDATA;
                end
            end
            if (k == EXP_RSP) obs_rdata_end = RSP_RDATA;
            if (REQ_READY === 1'b1 && obs_ready_k < 0) obs_ready_k = k;
            if (k == 0 && !hold) REQ_VALID = 1'b0;
            if (k == pulse_k) REQ_VALID = 1'b1;
            if (pulse_k >= 0 && k == pulse_k + 1) REQ_VALID = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        n_cmp++; if (REQ_READY !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", REQ_READY); end
        n_cmp++; if (RSP_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", RSP_VALID); end
        n_cmp++; if (RSP_RDATA !== '0) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h want 0", RSP_RDATA); end
        n_cmp++; if (MEM_RE !== 1'b0 || MEM_WE !== 1'b0) begin n_bad++; $display("FAIL rst_enables: got re=%b we=%b want 0/0", MEM_RE, MEM_WE); end
        n_cmp++; if (MEM_ADDR !== 32'd0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", MEM_ADDR); end
        n_cmp++; if (MEM_DIN !== 32'd0) begin n_bad++; $display("FAIL rst_mem_din: got %h want 0", MEM_DIN); end
        RST = 1'b1;
        for (int f = 1; f <= DRAIN; f++) begin
            @(negedge CLK);
            n_cmp++;
            if (REQ_READY !== (f == DRAIN)) begin
                n_bad++; $display("FAIL drain_ready[%0d]: got %b want %b", f, REQ_READY, (f == DRAIN));
            end
        end
    endtask

    task automatic test_fill;
        logic [LW-1:0] exp_line;
        exp_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        do_txn(1'b0, 32'h40, '0, 1'b0, -1);
        n_cmp++; if (obs_wait !== 0) begin n_bad++; $display("FAIL fill_accept_wait: got %0d want 0", obs_wait); end
        n_cmp++; if (obs_rsp_k !== EXP_RSP) begin n_bad++; $display("FAIL fill_rsp_time: got %0d want %0d", obs_rsp_k, EXP_RSP); end
        n_cmp++; if (obs_rsp_cnt !== 1) begin n_bad++; $display("FAIL fill_rsp_pulses: got %0d want 1", obs_rsp_cnt); end
        n_cmp++; if (obs_en_cnt !== EXP_EN) begin n_bad++; $display("FAIL fill_re_cycles: got %0d want %0d", obs_en_cnt, EXP_EN); end
        n_cmp++; if (obs_other_cnt !== 0) begin n_bad++; $display("FAIL fill_we_seen: got %0d want 0", obs_other_cnt); end
        n_cmp++; if (obs_ready_k !== EXP_RDY) begin n_bad++; $display("FAIL fill_ready_back: got %0d want %0d", obs_ready_k, EXP_RDY); end
        n_cmp++; if (obs_line !== exp_line) begin n_bad++; $display("FAIL fill_line: got %h want %h", obs_line, exp_line); end
        for (int k = 0; k <= D + B; k++) begin
            n_cmp++;
            if (addr_tr[k] !== 32'h40 + 32'(beat_at(k))) begin
                n_bad++; $display("FAIL fill_addr[E%0d]: got %h want %h", k, addr_tr[k], 32'h40 + 32'(beat_at(k)));
            end
        end
        last_line = exp_line;
    endtask

    task automatic test_unaligned;
        do_txn(1'b0, 32'h43, '0, 1'b0, -1);
        n_cmp++; if (obs_line !== ref_line(32'h40)) begin n_bad++; $display("FAIL unal_line: got %h want %h", obs_line, ref_line(32'h40)); end
        n_cmp++; if (obs_rsp_k !== EXP_RSP) begin n_bad++; $display("FAIL unal_rsp_time: got %0d want %0d", obs_rsp_k, EXP_RSP); end
        for (int k = 0; k <= D + B; k++) begin
            n_cmp++;
            if (addr_tr[k] !== 32'h40 + 32'(beat_at(k))) begin
                n_bad++; $display("FAIL unal_addr[E%0d]: got %h want %h", k, addr_tr[k], 32'h40 + 32'(beat_at(k)));
            end
        end
        last_line = ref_line(32'h40);
    endtask

    task automatic test_write_then_fill;
        logic [LW-1:0] wline;
        wline = {32'h44, 32'h33, 32'h22, 32'h11};
        do_txn(1'b1, 32'h80, wline, 1'b0, -1);
        ref_write(32'h80, wline);
        n_cmp++; if (obs_en_cnt !== EXP_EN) begin n_bad++; $display("FAIL wb_we_cycles: got %0d want %0d", obs_en_cnt, EXP_EN); end
        n_cmp++; if (obs_other_cnt !== 0) begin n_bad++; $display("FAIL wb_re_seen: got %0d want 0", obs_other_cnt); end
        n_cmp++; if (obs_rsp_k !== EXP_RSP) begin n_bad++; $display("FAIL wb_rsp_time: got %0d want %0d", obs_rsp_k, EXP_RSP); end
        n_cmp++; if (obs_rdata_end !== last_line) begin n_bad++; $display("FAIL wb_rdata_kept: got %h want %h", obs_rdata_end, last_line); end
        for (int k = 0; k <= D + B; k++) begin
            n_cmp++;
            if (din_tr[k] !== wline[32*beat_at(k) +: 32] || addr_tr[k] !== 32'h80 + 32'(beat_at(k))) begin
                n_bad++; $display("FAIL wb_bus[E%0d]: got addr=%h din=%h want addr=%h din=%h", k, addr_tr[k], din_tr[k],
                                  32'h80 + 32'(beat_at(k)), wline[32*beat_at(k) +: 32]);
            end
        end
        do_txn(1'b0, 32'h80, '0, 1'b0, -1);
        n_cmp++; if (obs_line !== wline) begin n_bad++; $display("FAIL wb_readback: got %h want %h", obs_line, wline); end
        last_line = wline;
    endtask

    task automatic test_back_to_back;
        int b0, e0, en1;
        logic [LW-1:0] line1;
        b0 = m_bursts;
        e0 = m_beats;
        do_txn(1'b0, 32'h40, '0, 1'b1, -1);
        en1   = obs_en_cnt;
        line1 = obs_line;
        do_txn(1'b0, 32'h80, '0, 1'b0, -1);
        n_cmp++; if (line1 !== ref_line(32'h40)) begin n_bad++; $display("FAIL b2b_line1: got %h want %h", line1, ref_line(32'h40)); end
        n_cmp++; if (en1 !== EXP_EN) begin n_bad++; $display("FAIL b2b_re_gap: got %0d re cycles want %0d", en1, EXP_EN); end
        n_cmp++; if (obs_wait !== 0) begin n_bad++; $display("FAIL b2b_second_accept: got wait %0d want 0", obs_wait); end
        n_cmp++; if (obs_line !== ref_line(32'h80)) begin n_bad++; $display("FAIL b2b_line2: got %h want %h", obs_line, ref_line(32'h80)); end
        n_cmp++; if (m_bursts - b0 !== 2) begin n_bad++; $display("FAIL b2b_bursts: got %0d want 2", m_bursts - b0); end
        n_cmp++; if (m_beats - e0 !== 2 * B) begin n_bad++; $display("FAIL b2b_beats: got %0d want %0d", m_beats - e0, 2 * B); end
        last_line = obs_line;
    endtask

    task automatic test_busy_stall;
        int b0, re_hi;
        b0 = m_bursts;
        do_txn(1'b0, 32'h40, '0, 1'b0, 4);
        n_cmp++; if (obs_ready_k !== EXP_RDY) begin n_bad++; $display("FAIL stall_ready: got first ready %0d want %0d", obs_ready_k, EXP_RDY); end
        n_cmp++; if (obs_rsp_cnt !== 1) begin n_bad++; $display("FAIL stall_rsp_pulses: got %0d want 1", obs_rsp_cnt); end
        n_cmp++; if (obs_line !== ref_line(32'h40)) begin n_bad++; $display("FAIL stall_line: got %h want %h", obs_line, ref_line(32'h40)); end
        re_hi = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (MEM_RE !== 1'b0) re_hi++;
        end
        n_cmp++; if (re_hi !== 0) begin n_bad++; $display("FAIL stall_extra_re: got %0d cycles want 0", re_hi); end
        n_cmp++; if (m_bursts - b0 !== 1) begin n_bad++; $display("FAIL stall_bursts: got %0d want 1", m_bursts - b0); end
        last_line = obs_line;
    endtask

    task automatic test_random;
        logic          wr;
        logic [31:0]   addr, base;
        logic [LW-1:0] wline;
        for (int it = 0; it < 12; it++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom;
            base = align(addr);
            for (int i = 0; i < B; i++) wline[32*i +: 32] = $urandom;
            do_txn(wr, addr, wline, 1'b0, -1);
            n_cmp++; if (obs_rsp_k !== EXP_RSP || obs_rsp_cnt !== 1) begin n_bad++; $display("FAIL rand%0d_rsp: got k=%0d n=%0d want k=%0d n=1", it, obs_rsp_k, obs_rsp_cnt, EXP_RSP); end
            n_cmp++; if (obs_en_cnt !== EXP_EN || obs_other_cnt !== 0) begin n_bad++; $display("FAIL rand%0d_enables: got en=%0d other=%0d want %0d/0", it, obs_en_cnt, obs_other_cnt, EXP_EN); end
            for (int k = 0; k <= D + B; k++) begin
                n_cmp++;
                if (addr_tr[k] !== base + 32'(beat_at(k))) begin
                    n_bad++; $display("FAIL rand%0d_addr[E%0d]: got %h want %h", it, k, addr_tr[k], base + 32'(beat_at(k)));
                end
            end
            if (wr) begin
                ref_write(base, wline);
                n_cmp++; if (obs_rdata_end !== last_line) begin n_bad++; $display("FAIL rand%0d_rdata_kept: got %h want %h", it, obs_rdata_end, last_line); end
                do_txn(1'b0, base, '0, 1'b0, -1);
                n_cmp++; if (obs_line !== wline) begin n_bad++; $display("FAIL rand%0d_readback: got %h want %h", it, obs_line, wline); end
                last_line = wline;
            end else begin
                n_cmp++; if (obs_line !== ref_line(base)) begin n_bad++; $display("FAIL rand%0d_fill: got %h want %h", it, obs_line, ref_line(base)); end
                last_line = ref_line(base);
            end
        end
    endtask

    task automatic test_reset_midburst;
        int rsp_seen;
        REQ_VALID = 1'b1;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = 32'h40;
        @(posedge CLK);
        for (int k = 0; k <= 13; k++) begin
            @(negedge CLK);
            if (k == 0) REQ_VALID = 1'b0;
        end
        RST = 1'b0;
        #1;
        n_cmp++; if (MEM_RE !== 1'b0 || MEM_WE !== 1'b0) begin n_bad++; $display("FAIL mid_rst_enables: got re=%b we=%b want 0/0", MEM_RE, MEM_WE); end
        n_cmp++; if (RSP_RDATA !== '0) begin n_bad++; $display("FAIL mid_rst_rdata: got %h want 0", RSP_RDATA); end
        n_cmp++; if (MEM_ADDR !== 32'd0 || MEM_DIN !== 32'd0) begin n_bad++; $display("FAIL mid_rst_bus: got addr=%h din=%h want 0/0", MEM_ADDR, MEM_DIN); end
        n_cmp++; if (REQ_READY !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", REQ_READY); end
        rsp_seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b0) rsp_seen++;
        end
        RST = 1'b1;
        for (int f = 1; f <= DRAIN; f++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b0) rsp_seen++;
            n_cmp++;
            if (REQ_READY !== (f == DRAIN)) begin
                n_bad++; $display("FAIL mid_drain_ready[%0d]: got %b want %b", f, REQ_READY, (f == DRAIN));
            end
        end
        n_cmp++; if (rsp_seen !== 0) begin n_bad++; $display("FAIL mid_rsp_valid: got %0d pulses want 0", rsp_seen); end
        do_txn(1'b0, 32'h40, '0, 1'b0, -1);
        n_cmp++; if (obs_line !== ref_line(32'h40)) begin n_bad++; $display("FAIL mid_refill: got %h want %h", obs_line, ref_line(32'h40)); end
        n_cmp++; if (obs_rsp_k !== EXP_RSP) begin n_bad++; $display("FAIL mid_refill_time: got %0d want %0d", obs_rsp_k, EXP_RSP); end
    endtask

    task automatic test_protocol;
        n_cmp++; if (both_viol !== 0) begin n_bad++; $display("FAIL re_we_overlap: got %0d cycles want 0", both_viol); end
    endtask

    initial begin
        RST       = 1'b0;
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        last_line = '0;
        @(negedge CLK);
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        @(negedge CLK);
        test_reset;
        test_fill;
        test_unaligned;
        test_write_then_fill;
        test_back_to_back;
        test_busy_stall;
        test_random;
        test_reset_midburst;
        test_protocol;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
